// File: rtl/keystone_stream_shell.sv
// AXI4-Stream shell around the keystone correction core: per-frame correct/bypass routing,
// frame-stable coefficient shadowing, core drain on mode change and a registered 2-entry egress skid.
module keystone_stream_shell #(
  parameter int DATA_W          = 64,
  parameter int COEF_W          = 32,
  parameter int NUM_COEF        = 9,
  parameter int MAX_OUTSTANDING = 64,
  parameter int LINE_CNT_W      = 12,
  parameter int FRAME_CNT_W     = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         sw_reset,
  input  logic                         enable,
  input  logic [NUM_COEF*COEF_W-1:0]   coef_in,
  output logic [NUM_COEF*COEF_W-1:0]   coef_out,
  input  logic [DATA_W-1:0]            s_tdata,
  input  logic                         s_tvalid,
  input  logic                         s_tuser,
  input  logic                         s_tlast,
  output logic                         s_tready,
  output logic [DATA_W-1:0]            m_tdata,
  output logic                         m_tvalid,
  output logic                         m_tuser,
  output logic                         m_tlast,
  input  logic                         m_tready,
  output logic [DATA_W-1:0]            cx_tdata,
  output logic                         cx_tvalid,
  output logic                         cx_tuser,
  output logic                         cx_tlast,
  input  logic                         cx_tready,
  input  logic [DATA_W-1:0]            cr_tdata,
  input  logic                         cr_tvalid,
  input  logic                         cr_tuser,
  input  logic                         cr_tlast,
  output logic                         cr_tready,
  output logic                         core_clear,
  output logic                         mode_active,
  output logic [FRAME_CNT_W-1:0]       frame_count,
  output logic [LINE_CNT_W-1:0]        line_count
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  localparam logic [1:0] WAIT_SOF = 2'd0;
  localparam logic [1:0] RUN      = 2'd1;
  localparam logic [1:0] DRAIN    = 2'd2;

  logic [1:0]                   r_state;
  logic                         r_modeActive;
  logic [NUM_COEF*COEF_W-1:0]   r_coef;
  logic [FRAME_CNT_W-1:0]       r_frameCnt;
  logic [LINE_CNT_W-1:0]        r_lineCnt;
  logic [OUT_W-1:0]             r_outstanding;
  logic                         r_clearPend;

  logic [DATA_W-1:0]            r_mData;
  logic                         r_mValid;
  logic                         r_mUser;
  logic                         r_mLast;
  logic [DATA_W-1:0]            r_skData;
  logic                         r_skValid;
  logic                         r_skUser;
  logic                         r_skLast;

  logic                         w_rstAny;
  logic                         w_isWait;
  logic                         w_isRun;
  logic                         w_isDrain;
  logic                         w_outFull;
  logic                         w_outEmpty;
  logic                         w_skRdy;
  logic                         w_coreRdy;
  logic                         w_sofOk;
  logic                         w_sofStall;
  logic                         w_sofTake;
  logic                         w_fwdMode;
  logic                         w_sFwd;
  logic                         w_skFromCore;
  logic                         w_inValid;
  logic [DATA_W-1:0]            w_inData;
  logic                         w_inUser;
  logic                         w_inLast;
  logic                         w_inFire;
  logic                         w_outLoad;
  logic                         w_sFire;
  logic                         w_sofAcc;
  logic                         w_cxFire;
  logic                         w_crFire;

  assign w_rstAny   = reset | sw_reset;
  assign w_isWait   = (r_state == WAIT_SOF);
  assign w_isRun    = (r_state == RUN);
  assign w_isDrain  = (r_state == DRAIN);
  assign w_outFull  = (r_outstanding >= OUT_MAX);
  assign w_outEmpty = (r_outstanding == '0);
  assign w_skRdy    = ~r_skValid & ~w_rstAny;
  assign w_coreRdy  = cx_tready & ~w_outFull & ~w_rstAny;

  // A SOF may only open a new frame without draining if the mode is unchanged or the core is empty.
  assign w_sofOk    = (enable == r_modeActive) | w_outEmpty;
  assign w_sofStall = w_isRun & s_tvalid & s_tuser & ~w_sofOk;
  assign w_sofTake  = s_tvalid & s_tuser & (w_isWait | (w_isRun & w_sofOk));
  assign w_fwdMode  = w_sofTake ? enable : r_modeActive;
  assign w_sFwd     = s_tvalid & ((w_isRun & ~w_sofStall) | (w_isWait & s_tuser));

  assign w_skFromCore = w_isDrain | (w_isRun & r_modeActive & ~(w_sofTake & ~enable));

  always_comb begin
    s_tready = 1'b0;
    if (!w_rstAny) begin
      if (w_isWait) begin
        s_tready = s_tuser ? (enable ? w_coreRdy : w_skRdy) : 1'b1;
      end else if (w_isRun && !w_sofStall) begin
        s_tready = w_fwdMode ? w_coreRdy : w_skRdy;
      end
    end
  end

  assign cx_tvalid = w_sFwd & w_fwdMode & ~w_outFull & ~w_rstAny;
  assign cx_tdata  = s_tdata;
  assign cx_tuser  = s_tuser;
  assign cx_tlast  = s_tlast;
  assign cr_tready = w_skFromCore & w_skRdy;

  assign w_inValid = w_skFromCore ? cr_tvalid : (w_sFwd & ~w_fwdMode);
  assign w_inData  = w_skFromCore ? cr_tdata  : s_tdata;
  assign w_inUser  = w_skFromCore ? cr_tuser  : s_tuser;
  assign w_inLast  = w_skFromCore ? cr_tlast  : s_tlast;
  assign w_inFire  = w_inValid & w_skRdy;
  assign w_outLoad = ~r_mValid | m_tready;

  assign w_sFire  = s_tvalid & s_tready;
  assign w_sofAcc = w_sFire & w_sofTake;
  assign w_cxFire = cx_tvalid & cx_tready;
  assign w_crFire = cr_tvalid & cr_tready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= WAIT_SOF;
      r_modeActive  <= 1'b0;
      r_coef        <= '0;
      r_frameCnt    <= '0;
      r_lineCnt     <= '0;
      r_outstanding <= '0;
      r_clearPend   <= 1'b1;
    end else if (sw_reset) begin
      r_state       <= WAIT_SOF;
      r_modeActive  <= 1'b0;
      r_coef        <= '0;
      r_frameCnt    <= '0;
      r_lineCnt     <= '0;
      r_outstanding <= '0;
      r_clearPend   <= 1'b1;
    end else begin
      r_clearPend <= 1'b0;
      case (r_state)
        WAIT_SOF: if (w_sofAcc) r_state <= RUN;
        RUN:      if (w_sofStall) r_state <= DRAIN;
        DRAIN:    if (w_outEmpty) r_state <= WAIT_SOF;
        default:  r_state <= WAIT_SOF;
      endcase

      if (w_sofAcc) begin
        r_modeActive <= enable;
        r_coef       <= coef_in;
        r_frameCnt   <= r_frameCnt + FRAME_CNT_W'(1);
        r_lineCnt    <= s_tlast ? LINE_CNT_W'(1) : '0;
      end else if (w_sFire && w_sFwd && s_tlast && (r_lineCnt != '1)) begin
        r_lineCnt <= r_lineCnt + LINE_CNT_W'(1);
      end

      if (w_cxFire && !w_crFire) begin
        r_outstanding <= r_outstanding + OUT_W'(1);
      end else if (!w_cxFire && w_crFire && !w_outEmpty) begin
        r_outstanding <= r_outstanding - OUT_W'(1);
      end
    end
  end

  // Output register is the head; the skid entry only fills when the head is stalled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mData   <= '0;
      r_mValid  <= 1'b0;
      r_mUser   <= 1'b0;
      r_mLast   <= 1'b0;
      r_skData  <= '0;
      r_skValid <= 1'b0;
      r_skUser  <= 1'b0;
      r_skLast  <= 1'b0;
    end else if (sw_reset) begin
      r_mData   <= '0;
      r_mValid  <= 1'b0;
      r_mUser   <= 1'b0;
      r_mLast   <= 1'b0;
      r_skData  <= '0;
      r_skValid <= 1'b0;
      r_skUser  <= 1'b0;
      r_skLast  <= 1'b0;
    end else if (w_outLoad) begin
      if (r_skValid) begin
        r_mData   <= r_skData;
        r_mUser   <= r_skUser;
        r_mLast   <= r_skLast;
        r_mValid  <= 1'b1;
        r_skValid <= 1'b0;
      end else begin
        r_mValid <= w_inFire;
        if (w_inFire) begin
          r_mData <= w_inData;
          r_mUser <= w_inUser;
          r_mLast <= w_inLast;
        end
      end
    end else if (w_inFire) begin
      r_skData  <= w_inData;
      r_skUser  <= w_inUser;
      r_skLast  <= w_inLast;
      r_skValid <= 1'b1;
    end
  end

  assign m_tdata     = r_mData;
  assign m_tvalid    = r_mValid;
  assign m_tuser     = r_mUser;
  assign m_tlast     = r_mLast;
  assign coef_out    = r_coef;
  assign mode_active = r_modeActive;
  assign frame_count = r_frameCnt;
  assign line_count  = r_lineCnt;
  assign core_clear  = r_clearPend & ~w_rstAny;

endmodule

// File: tb/tb_keystone_stream_shell.sv
// Directed bench for keystone_stream_shell: scoreboarded egress stream, loopback core with a
// 3-cycle delay, and hand-computed expectations for counters, coefficients and mode.
module tb_keystone_stream_shell;

  localparam int DW = 64;
  localparam int CW = 288;
  localparam logic [CW-1:0] COEF_A = {9{32'hA5A5_0001}};
  localparam logic [CW-1:0] COEF_B = {9{32'h5A5A_0002}};

  typedef struct packed {
    logic [DW-1:0] d;
    logic          u;
    logic          l;
    logic [31:0]   t;
  } coreBeat_t;

  logic          clock;
  logic          reset;
  logic          swReset;
  logic          enable;
  logic [CW-1:0] coefIn;
  logic [CW-1:0] coef_out;
  logic [DW-1:0] sTdata;
  logic          sTvalid;
  logic          sTuser;
  logic          sTlast;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tuser;
  logic          m_tlast;
  logic          mTready;
  logic [DW-1:0] cx_tdata;
  logic          cx_tvalid;
  logic          cx_tuser;
  logic          cx_tlast;
  logic          cxTready;
  logic [DW-1:0] crTdata;
  logic          crTvalid;
  logic          crTuser;
  logic          crTlast;
  logic          cr_tready;
  logic          core_clear;
  logic          mode_active;
  logic [15:0]   frame_count;
  logic [11:0]   line_count;

  int            assertCount = 0;
  int            failCount = 0;
  int            cxCount = 0;
  logic [31:0]   cyc = 0;
  logic          crHold = 1'b0;
  logic          randReady = 1'b0;
  logic [65:0]   expQ[$];
  coreBeat_t     coreQ[$];

  keystone_stream_shell dut (
    .clock(clock), .reset(reset), .sw_reset(swReset), .enable(enable),
    .coef_in(coefIn), .coef_out(coef_out),
    .s_tdata(sTdata), .s_tvalid(sTvalid), .s_tuser(sTuser), .s_tlast(sTlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tuser(m_tuser), .m_tlast(m_tlast), .m_tready(mTready),
    .cx_tdata(cx_tdata), .cx_tvalid(cx_tvalid), .cx_tuser(cx_tuser), .cx_tlast(cx_tlast), .cx_tready(cxTready),
    .cr_tdata(crTdata), .cr_tvalid(crTvalid), .cr_tuser(crTuser), .cr_tlast(crTlast), .cr_tready(cr_tready),
    .core_clear(core_clear), .mode_active(mode_active),
    .frame_count(frame_count), .line_count(line_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    forever begin
      @(posedge clock);
      cyc = cyc + 32'd1;
    end
  end

  task automatic checkOutput(input string tag, input logic [CW-1:0] observed, input logic [CW-1:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [DW-1:0] mkData(input int f, input int l, input int b);
    return 64'hC0DE_0000_0000_0000 | DW'(f << 16) | DW'(l << 8) | DW'(b);
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Presents one beat and holds it until accepted; forwarded beats join the scoreboard.
  task automatic applyStimulus(input logic [DW-1:0] d, input logic u, input logic l, input logic fwd);
    int waitCnt;
    waitCnt = 0;
    sTdata = d;
    sTuser = u;
    sTlast = l;
    sTvalid = 1'b1;
    @(negedge clock);
    while (!s_tready && waitCnt < 200) begin
      @(negedge clock);
      waitCnt++;
    end
    if (!s_tready) checkOutput("s_tready timeout", CW'(s_tready), CW'(1));
    else if (fwd) expQ.push_back({u, l, d});
    @(posedge clock);
    #1;
    sTvalid = 1'b0;
  endtask

  task automatic sendLine(input int f, input int l, input int n, input logic withSof);
    for (int b = 0; b < n; b++)
      applyStimulus(mkData(f, l, b), withSof && (b == 0), b == n - 1, 1'b1);
  endtask

  task automatic waitDrain(input int limit);
    int n;
    n = 0;
    while ((expQ.size() != 0 || coreQ.size() != 0) && n < limit) begin
      @(posedge clock);
      #1;
      n++;
    end
    checkOutput("drain complete", CW'(expQ.size()), CW'(0));
  endtask

  // Egress scoreboard: whenever m_tvalid is up the head must match, stalled or not.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && !swReset) begin
        if (cx_tvalid) cxCount++;
        if (m_tvalid) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected m beat", CW'(expQ.size()), CW'(1));
          end else begin
            checkOutput("m beat", CW'({m_tuser, m_tlast, m_tdata}), CW'(expQ[0]));
            if (mTready) void'(expQ.pop_front());
          end
        end
      end
    end
  end

  // Loopback core: cx beats reappear on cr no earlier than 3 cycles later.
  initial begin
    coreBeat_t nb;
    crTvalid = 1'b0;
    crTdata = '0;
    crTuser = 1'b0;
    crTlast = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset && !swReset) begin
        if (crTvalid && cr_tready) void'(coreQ.pop_front());
        if (cx_tvalid && cxTready) begin
          nb.d = cx_tdata;
          nb.u = cx_tuser;
          nb.l = cx_tlast;
          nb.t = cyc;
          coreQ.push_back(nb);
        end
      end
      @(posedge clock);
      #1;
      if (coreQ.size() > 0 && !crHold && cyc >= coreQ[0].t + 32'd3) begin
        crTvalid = 1'b1;
        crTdata = coreQ[0].d;
        crTuser = coreQ[0].u;
        crTlast = coreQ[0].l;
      end else begin
        crTvalid = 1'b0;
      end
    end
  end

  initial begin
    mTready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      mTready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    swReset = 1'b0;
    enable = 1'b0;
    coefIn = COEF_A;
    sTdata = '0;
    sTvalid = 1'b0;
    sTuser = 1'b0;
    sTlast = 1'b0;
    cxTready = 1'b1;

    repeat (3) @(negedge clock);
    checkOutput("reset s_tready", CW'(s_tready), CW'(0));
    checkOutput("reset core_clear", CW'(core_clear), CW'(0));
    checkOutput("reset m_tvalid", CW'(m_tvalid), CW'(0));
    checkOutput("reset cr_tready", CW'(cr_tready), CW'(0));
    checkOutput("reset mode", CW'(mode_active), CW'(0));
    checkOutput("reset coef", coef_out, CW'(0));
    checkOutput("reset frame_count", CW'(frame_count), CW'(0));
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("core_clear after reset", CW'(core_clear), CW'(1));
    checkOutput("wait_sof s_tready", CW'(s_tready), CW'(1));
    @(posedge clock);
    #1;
    @(negedge clock);
    checkOutput("core_clear single pulse", CW'(core_clear), CW'(0));
    @(posedge clock);
    #1;

    $display("[TB] sync discard then bypass frame");
    for (int i = 0; i < 5; i++) applyStimulus(mkData(0, 0, i), 1'b0, 1'b0, 1'b0);
    idle(2);
    checkOutput("discarded beats absent", CW'(m_tvalid), CW'(0));
    cxCount = 0;
    for (int l = 0; l < 4; l++) begin
      for (int b = 0; b < 8; b++) begin
        applyStimulus(mkData(1, l, b), (l == 0) && (b == 0), b == 7, 1'b1);
        if (l == 0 && b == 0)
          checkOutput("sof latency", CW'({m_tvalid, m_tuser, m_tdata}), CW'({1'b1, 1'b1, mkData(1, 0, 0)}));
      end
    end
    waitDrain(100);
    checkOutput("bypass frame_count", CW'(frame_count), CW'(1));
    checkOutput("bypass line_count", CW'(line_count), CW'(4));
    checkOutput("bypass no cx", CW'(cxCount), CW'(0));

    $display("[TB] correct mode with coefficient shadowing");
    enable = 1'b1;
    coefIn = COEF_A;
    sendLine(2, 0, 8, 1'b1);
    checkOutput("coef latched at sof", coef_out, COEF_A);
    checkOutput("mode correct", CW'(mode_active), CW'(1));
    coefIn = COEF_B;
    enable = 1'b0;
    sendLine(2, 1, 8, 1'b0);
    checkOutput("coef stable mid-frame", coef_out, COEF_A);
    checkOutput("mode stable mid-frame", CW'(mode_active), CW'(1));
    checkOutput("line_count frame2", CW'(line_count), CW'(2));
    enable = 1'b1;
    sendLine(3, 0, 4, 1'b1);
    checkOutput("coef update next sof", coef_out, COEF_B);
    checkOutput("frame_count frame3", CW'(frame_count), CW'(3));
    waitDrain(200);

    $display("[TB] mode switch with 3 beats in the core");
    crHold = 1'b1;
    sendLine(4, 0, 3, 1'b1);
    idle(4);
    enable = 1'b0;
    fork
      applyStimulus(mkData(5, 0, 0), 1'b1, 1'b0, 1'b1);
      begin
        repeat (3) begin
          @(negedge clock);
          checkOutput("drain stall s_tready", CW'(s_tready), CW'(0));
        end
        crHold = 1'b0;
      end
    join
    checkOutput("core drained before sof", CW'(coreQ.size()), CW'(0));
    checkOutput("mode bypass after switch", CW'(mode_active), CW'(0));
    cxCount = 0;
    for (int b = 1; b < 8; b++) applyStimulus(mkData(5, 0, b), 1'b0, b == 7, 1'b1);
    waitDrain(100);
    checkOutput("switch no cx in bypass", CW'(cxCount), CW'(0));
    checkOutput("frame_count frame5", CW'(frame_count), CW'(5));

    $display("[TB] random backpressure over 256 beats");
    randReady = 1'b1;
    for (int l = 0; l < 8; l++) sendLine(6, l, 32, l == 0);
    waitDrain(2000);
    randReady = 1'b0;
    checkOutput("backpressure line_count", CW'(line_count), CW'(8));
    checkOutput("backpressure frame_count", CW'(frame_count), CW'(6));

    $display("[TB] soft reset mid-frame");
    sendLine(7, 0, 3, 1'b1);
    swReset = 1'b1;
    @(negedge clock);
    checkOutput("sw_reset s_tready", CW'(s_tready), CW'(0));
    checkOutput("sw_reset core_clear low", CW'(core_clear), CW'(0));
    @(posedge clock);
    #1;
    swReset = 1'b0;
    expQ.delete();
    @(negedge clock);
    checkOutput("sw_reset m_tvalid", CW'(m_tvalid), CW'(0));
    checkOutput("sw_reset core_clear pulse", CW'(core_clear), CW'(1));
    checkOutput("sw_reset frame_count", CW'(frame_count), CW'(0));
    checkOutput("sw_reset line_count", CW'(line_count), CW'(0));
    checkOutput("sw_reset mode", CW'(mode_active), CW'(0));
    checkOutput("sw_reset coef", coef_out, CW'(0));
    @(posedge clock);
    #1;
    @(negedge clock);
    checkOutput("sw_reset core_clear once", CW'(core_clear), CW'(0));
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) applyStimulus(mkData(7, 1, i), 1'b0, 1'b0, 1'b0);
    idle(2);
    checkOutput("post sw_reset discard", CW'(m_tvalid), CW'(0));
    sendLine(8, 0, 4, 1'b1);
    waitDrain(100);
    checkOutput("post sw_reset frame_count", CW'(frame_count), CW'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
